// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one iterative sine/cosine CORDIC core between N_REQ requesters.
// Accepted angles are issued to the core one at a time; results (or a timeout error) return to the owner.
module cordic_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 20,
    parameter int unsigned PTR_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_angle,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [7:0]           rsp_sin,
    output logic [7:0]           rsp_cos,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [7:0]           core_angle,
    input  logic                 core_done,
    input  logic [7:0]           core_sin,
    input  logic [7:0]           core_cos,
    output logic                 busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_sin_q, rsp_sin_d;
    logic [7:0]         rsp_cos_q, rsp_cos_d;
    logic               rsp_err_q, rsp_err_d;
    logic               core_start_q, core_start_d;
    logic [7:0]         core_angle_q, core_angle_d;
    logic               busy_q, busy_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     scan_sum;
    logic               accept;

    // Round-robin scan starting at ptr, wrapping modulo N_REQ; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[PTR_W'(scan_sum)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(scan_sum);
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && grant_found;
    assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        timer_d      = timer_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sin_d    = rsp_sin_q;
        rsp_cos_d    = rsp_cos_q;
        rsp_err_d    = rsp_err_q;
        core_start_d = 1'b0;
        core_angle_d = core_angle_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d      = grant_idx;
                    core_angle_d = req_angle[{grant_idx, 3'b000} +: 8];
                    ptr_d        = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                    core_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A done arriving on the timeout cycle still counts as a good result.
                if (core_done) begin
                    rsp_sin_d   = core_sin;
                    rsp_cos_d   = core_cos;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    state_d     = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    rsp_sin_d   = '0;
                    rsp_cos_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            timer_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_sin_q    <= '0;
            rsp_cos_q    <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_angle_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            timer_q      <= timer_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sin_q    <= rsp_sin_d;
            rsp_cos_q    <= rsp_cos_d;
            rsp_err_q    <= rsp_err_d;
            core_start_q <= core_start_d;
            core_angle_q <= core_angle_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_sin    = rsp_sin_q;
    assign rsp_cos    = rsp_cos_q;
    assign rsp_err    = rsp_err_q;
    assign core_start = core_start_q;
    assign core_angle = core_angle_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: fixed-latency core model, job table, and hand-written corner-case sequences.
module tb_cordic_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_angle = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [7:0]  rsp_sin, rsp_cos, core_angle, core_sin, core_cos;
    logic        rsp_err, core_start, core_done, busy;

    always #5 clk = ~clk;

    cordic_sched #(.N_REQ(4), .TIMEOUT(20), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err),
        .core_start(core_start), .core_angle(core_angle),
        .core_done(core_done), .core_sin(core_sin), .core_cos(core_cos),
        .busy(busy)
    );

    // Core model: done pulses m_lat cycles after the start cycle; m_lat==0 means never.
    int          m_lat = 0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [7:0]  m_sin = '0, m_cos = '0;
    logic        stray_done = 1'b0;
    logic [7:0]  stray_sin = '0, stray_cos = '0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (core_start && m_lat != 0) begin
            m_cnt <= m_lat - 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end
    end

    assign core_done = m_done | stray_done;
    assign core_sin  = stray_done ? stray_sin : m_sin;
    assign core_cos  = stray_done ? stray_cos : m_cos;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] angles;
        int          lat;
        logic [7:0]  sin_in, cos_in;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_angle;
        int          exp_cyc;
        logic [7:0]  exp_sin, exp_cos;
        logic        exp_err;
    } vec_t;

    // One complete job from IDLE: grant, issue, response timing/values, handshake back to IDLE.
    task automatic run_job(input vec_t v, input int id);
        int cyc;
        m_lat = v.lat; m_sin = v.sin_in; m_cos = v.cos_in;
        rsp_ready = '0;
        req_angle = v.angles;
        req_valid = v.valid;
        #1;
        chk($sformatf("v%0d grant", id), 32'(req_ready), 32'(v.exp_grant));
        step();
        req_valid = '0;
        chk($sformatf("v%0d core_start", id), 32'(core_start), 32'd1);
        chk($sformatf("v%0d core_angle", id), 32'(core_angle), 32'(v.exp_angle));
        cyc = 1;
        while (rsp_valid == 4'b0 && cyc < 40) begin
            step();
            cyc++;
        end
        chk($sformatf("v%0d rsp_cycle", id), 32'(cyc), 32'(v.exp_cyc));
        chk($sformatf("v%0d rsp_valid", id), 32'(rsp_valid), 32'(v.exp_grant));
        chk($sformatf("v%0d rsp_sin", id), 32'(rsp_sin), 32'(v.exp_sin));
        chk($sformatf("v%0d rsp_cos", id), 32'(rsp_cos), 32'(v.exp_cos));
        chk($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = v.exp_grant;
        step();
        rsp_ready = '0;
        chk($sformatf("v%0d rsp_clear", id), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d idle", id), 32'(busy), 32'd0);
    endtask

    vec_t vecs[6];
    logic [3:0] c_grant[5];
    logic [7:0] c_angle[5];

    initial begin
        int n;
        int cyc;

        // Table starts with ptr=1 (left there by the contention sequence).
        vecs[0] = '{4'b0001, 32'h44332232, 13, 8'h5A, 8'h5A, 4'b0001, 8'h32, 15, 8'h5A, 8'h5A, 1'b0};
        vecs[1] = '{4'b0101, 32'h44332211,  5, 8'h11, 8'h7F, 4'b0100, 8'h33,  7, 8'h11, 8'h7F, 1'b0};
        vecs[2] = '{4'b1001, 32'h44332211,  2, 8'h80, 8'hC0, 4'b1000, 8'h44,  4, 8'h80, 8'hC0, 1'b0};
        vecs[3] = '{4'b0110, 32'h44332211,  0, 8'hAA, 8'h55, 4'b0010, 8'h22, 22, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{4'b0011, 32'h44332211, 20, 8'h01, 8'hFF, 4'b0001, 8'h11, 22, 8'h01, 8'hFF, 1'b0};
        vecs[5] = '{4'b1111, 32'h44332211, 19, 8'h40, 8'h20, 4'b0010, 8'h22, 21, 8'h40, 8'h20, 1'b0};
        c_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        c_angle = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        // Reset values
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_sin", 32'(rsp_sin), 32'd0);
        chk("rst rsp_cos", 32'(rsp_cos), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst core_start", 32'(core_start), 32'd0);
        chk("rst core_angle", 32'(core_angle), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;

        // Contention from reset: all valid, requester 0 stays valid and is served fifth.
        m_lat = 3; m_sin = 8'h10; m_cos = 8'h20;
        rsp_ready = 4'hF;
        req_angle = 32'h44332211;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #1;
            while (req_ready == 4'b0 && n < 60) begin
                step();
                n++;
            end
            chk($sformatf("cont grant%0d", k), 32'(req_ready), 32'(c_grant[k]));
            step();
            chk($sformatf("cont angle%0d", k), 32'(core_angle), 32'(c_angle[k]));
            if (k != 0) req_valid = req_valid & ~c_grant[k];
        end
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk("cont drained", 32'(busy), 32'd0);
        rsp_ready = '0;
        req_valid = '0;

        for (int i = 0; i < 6; i++) run_job(vecs[i], i);

        // Back-pressure on requester 2 (ptr=2); other valids and non-owner readies must not disturb RESP.
        m_lat = 4; m_sin = 8'h3C; m_cos = 8'hD0;
        req_valid = 4'b0100;
        #1;
        chk("bp grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1011;
        rsp_ready = 4'b1011;
        cyc = 1;
        while (rsp_valid == 4'b0 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("bp rsp_cycle", 32'(cyc), 32'd6);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp rsp_valid%0d", i), 32'(rsp_valid), 32'b0100);
            chk($sformatf("bp sin%0d", i), 32'(rsp_sin), 32'h3C);
            chk($sformatf("bp cos%0d", i), 32'(rsp_cos), 32'hD0);
            chk($sformatf("bp err%0d", i), 32'(rsp_err), 32'd0);
            chk($sformatf("bp req_ready%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp core_start%0d", i), 32'(core_start), 32'd0);
            step();
        end
        rsp_ready = 4'hF;
        step();
        rsp_ready = '0;
        chk("bp release valid", 32'(rsp_valid), 32'd0);
        chk("bp release busy", 32'(busy), 32'd0);
        chk("bp next grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        step();

        // Timeout on requester 3 (ptr=3), then a late done in RESP and a stray done in IDLE.
        m_lat = 0;
        req_valid = 4'b1000;
        #1;
        chk("to grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        chk("to core_start", 32'(core_start), 32'd1);
        cyc = 1;
        while (rsp_valid == 4'b0 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("to rsp_cycle", 32'(cyc), 32'd22);
        chk("to rsp_valid", 32'(rsp_valid), 32'b1000);
        chk("to err", 32'(rsp_err), 32'd1);
        chk("to sin", 32'(rsp_sin), 32'd0);
        chk("to cos", 32'(rsp_cos), 32'd0);
        stray_sin = 8'h77; stray_cos = 8'h66; stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        chk("late rsp_valid", 32'(rsp_valid), 32'b1000);
        chk("late sin", 32'(rsp_sin), 32'd0);
        chk("late cos", 32'(rsp_cos), 32'd0);
        chk("late err", 32'(rsp_err), 32'd1);
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;
        chk("to idle", 32'(busy), 32'd0);
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        chk("stray busy", 32'(busy), 32'd0);
        chk("stray core_start", 32'(core_start), 32'd0);
        chk("stray rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray sin", 32'(rsp_sin), 32'd0);
        chk("stray err", 32'(rsp_err), 32'd1);

        // Reset five cycles after core_start (ptr=0, requester 1).
        req_valid = 4'b0010;
        #1;
        chk("rw grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("rw core_start", 32'(core_start), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("rw busy pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw busy", 32'(busy), 32'd0);
        chk("rw rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw rsp_err", 32'(rsp_err), 32'd0);
        chk("rw core_angle", 32'(core_angle), 32'd0);
        chk("rw core_start", 32'(core_start), 32'd0);
        step();
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("rw ptr reset grant", 32'(req_ready), 32'b0010);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Round-robin scheduler that shares one iterative 12-stage sine/cosine CORDIC core between N_REQ requesters.
- Each requester presents a signed 8-bit angle with a valid/ready handshake.
- The block serialises accepted angles into the core, waits for completion (with a timeout), and returns sine/cosine on a shared result bus, steered to the owning requester.
- Sits between the angle-producing clients and the cordic core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 20, max cycles from core_start to core_done before the job is aborted
- PTR_W, 2, width of grant pointer/index, ceil(log2(N_REQ))

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester angle valid
- req_angle  input  8*N_REQ  per-requester signed angle; requester i uses bits [8i+7:8i]
- req_ready  output  N_REQ  one-hot accept strobe
- rsp_valid  output  N_REQ  one-hot result valid, held until accepted
- rsp_ready  input  N_REQ  per-requester result accept
- rsp_sin  output  8  signed sine result
- rsp_cos  output  8  signed cosine result
- rsp_err  output  1  result produced by timeout, not by the core
- core_start  output  1  single-cycle start pulse to core
- core_angle  output  8  angle to core, stable from core_start until the job ends
- core_done  input  1  single-cycle completion pulse from core
- core_sin  input  8  core sine, valid with core_done
- core_cos  input  8  core cosine, valid with core_done
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, ptr=0, owner=0, timer=0.
  - All outputs 0: req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err, core_start, core_angle, busy.
- FSM has 4 states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration is combinational: scan from ptr upward, modulo N_REQ; the first i with req_valid[i]=1 wins.
  - req_ready is one-hot on the winner, and only in IDLE; all zero when no request.
  - On req_valid[i] & req_ready[i]: latch owner=i and core_angle=req_angle[i], set ptr=(i+1) mod N_REQ, go to ISSUE.
- ISSUE: core_start=1 for exactly this one cycle; timer=0; go to WAIT.
- WAIT:
  - timer increments every cycle.
  - core_done=1: latch rsp_sin=core_sin, rsp_cos=core_cos, rsp_err=0; go to RESP.
  - timer==TIMEOUT-1 with no done: rsp_sin=0, rsp_cos=0, rsp_err=1; go to RESP.
  - If done and timeout coincide, done wins (err=0).
- RESP:
  - rsp_valid[owner]=1; rsp_sin, rsp_cos and rsp_err are held stable.
  - On rsp_ready[owner]: clear rsp_valid and go to IDLE.
  - rsp_ready from non-owners is ignored.
  - No new request is accepted until the cycle after the handshake.
- Latency: accept at cycle t → core_start at t+1. A core with fixed latency L (done at t+1+L) → rsp_valid at t+2+L. Minimum spacing between accepts to the same requester is L+3 cycles.
- core_done outside WAIT, including a late done after a timeout: ignored, no state change.
- req_valid deasserting in IDLE before acceptance: legal, no side effect.
- Angle is passed through unmodified; range and sign handling belong to the core.
- Outputs rsp_* and core_* are registered; req_ready is combinational from req_valid and ptr.
- Reset asserted mid-operation (any state): immediate return to reset values; the in-flight job is dropped with no response.

Test Plan:
- Single request: req_valid[0]=1, angle 0x32; core model returns sin=0x5A, cos=0x5A after 13 cycles → req_ready[0] at cycle 0, core_start at 1, rsp_valid=4'b0001 at cycle 15 with sin=0x5A, cos=0x5A, err=0.
- Contention: all four requesters valid simultaneously from reset → grants in order 0,1,2,3. Requester 0 re-requests during job 0 → it is served fifth, after 3.
- Back-pressure: rsp_ready[2]=0 for 10 cycles while rsp_valid[2]=1 → sin/cos/err stable, req_ready stays 0, core_start stays 0; release → IDLE next cycle.
- Timeout: core model never pulses done → rsp_valid at ISSUE+TIMEOUT+1 with err=1, sin=cos=0. A late core_done afterwards is ignored.
- Stray done: core_done pulsed in IDLE and in RESP → no state change, outputs unchanged.
- Reset mid-WAIT: assert rst 5 cycles after core_start → all outputs 0 and busy=0 within the reset cycle. After release, requester 1 is granted first when both 1 and 3 are valid (ptr back to 0).
